// File: rtl/id_ex_stage_if.sv
// Bundle of ID-side operands, MEM/EX bypass sources, pipeline control and the
// registered ID/EX outputs shared between the decode driver and id_ex_stage.
interface id_ex_stage_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic              id_valid;
  logic [ADDR_W-1:0] id_p0_addr;
  logic [ADDR_W-1:0] id_p1_addr;
  logic              id_re0;
  logic              id_re1;
  logic [DATA_W-1:0] id_p0;
  logic [DATA_W-1:0] id_p1;
  logic [ADDR_W-1:0] id_dst_addr;
  logic              id_we;
  logic              id_ld;
  logic [DATA_W-1:0] ex_result;
  logic              mem_valid;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_dst_addr;
  logic [DATA_W-1:0] mem_result;
  logic              flush;
  logic              hold;
  logic              stall;
  logic              ex_valid;
  logic [DATA_W-1:0] ex_op0;
  logic [DATA_W-1:0] ex_op1;
  logic [ADDR_W-1:0] ex_dst_addr;
  logic              ex_we;
  logic              ex_ld;

  modport master (
    output id_valid, id_p0_addr, id_p1_addr, id_re0, id_re1, id_p0, id_p1,
           id_dst_addr, id_we, id_ld, ex_result, mem_valid, mem_we,
           mem_dst_addr, mem_result, flush, hold,
    input  stall, ex_valid, ex_op0, ex_op1, ex_dst_addr, ex_we, ex_ld
  );

  modport slave (
    input  id_valid, id_p0_addr, id_p1_addr, id_re0, id_re1, id_p0, id_p1,
           id_dst_addr, id_we, id_ld, ex_result, mem_valid, mem_we,
           mem_dst_addr, mem_result, flush, hold,
    output stall, ex_valid, ex_op0, ex_op1, ex_dst_addr, ex_we, ex_ld
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM operand forwarding, load-use bubble
// insertion, branch flush and downstream hold.
module id_ex_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input logic         clk,
  input logic         rst,
  id_ex_stage_if.slave bus
);

  logic              vld_p1;
  logic              we_p1;
  logic              ld_p1;
  logic [ADDR_W-1:0] dst_p1;
  logic [DATA_W-1:0] op0_p1;
  logic [DATA_W-1:0] op1_p1;

  logic              ex_fwd_ok;
  logic              mem_fwd_ok;
  logic [DATA_W-1:0] fwd0_p0;
  logic [DATA_W-1:0] fwd1_p0;
  logic              load_use;
  logic              bubble;

  // r0 is hardwired to zero; the younger EX producer shadows MEM.
  function automatic logic [DATA_W-1:0] fwd_operand(
    input logic [ADDR_W-1:0] src,
    input logic [DATA_W-1:0] rf_data,
    input logic              ex_ok,
    input logic [ADDR_W-1:0] ex_dst,
    input logic [DATA_W-1:0] ex_data,
    input logic              mem_ok,
    input logic [ADDR_W-1:0] mem_dst,
    input logic [DATA_W-1:0] mem_data
  );
    if (src == '0)                   return '0;
    if (ex_ok && (ex_dst == src))    return ex_data;
    if (mem_ok && (mem_dst == src))  return mem_data;
    return rf_data;
  endfunction

  // ---- ID stage (p0): forwarding and hazard detection ----
  assign ex_fwd_ok  = vld_p1 & we_p1 & ~ld_p1;
  assign mem_fwd_ok = bus.mem_valid & bus.mem_we;

  assign fwd0_p0 = fwd_operand(bus.id_p0_addr, bus.id_p0, ex_fwd_ok, dst_p1,
                               bus.ex_result, mem_fwd_ok, bus.mem_dst_addr,
                               bus.mem_result);
  assign fwd1_p0 = fwd_operand(bus.id_p1_addr, bus.id_p1, ex_fwd_ok, dst_p1,
                               bus.ex_result, mem_fwd_ok, bus.mem_dst_addr,
                               bus.mem_result);

  // A load's data only exists after MEM, so a dependent reader must wait a cycle.
  assign load_use = bus.id_valid & vld_p1 & ld_p1 & we_p1 & (dst_p1 != '0) &
                    ((bus.id_re0 & (bus.id_p0_addr == dst_p1)) |
                     (bus.id_re1 & (bus.id_p1_addr == dst_p1)));

  assign bus.stall = bus.hold | (load_use & ~bus.flush);
  assign bubble    = bus.flush | load_use | ~bus.id_valid;

  // ---- EX stage (p1): ID/EX pipeline register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      we_p1  <= 1'b0;
      ld_p1  <= 1'b0;
      dst_p1 <= '0;
      op0_p1 <= '0;
      op1_p1 <= '0;
    end else if (bus.hold) begin
      vld_p1 <= vld_p1;
      we_p1  <= we_p1;
      ld_p1  <= ld_p1;
      dst_p1 <= dst_p1;
      op0_p1 <= op0_p1;
      op1_p1 <= op1_p1;
    end else if (bubble) begin
      vld_p1 <= 1'b0;
      we_p1  <= 1'b0;
      ld_p1  <= 1'b0;
      dst_p1 <= '0;
      op0_p1 <= '0;
      op1_p1 <= '0;
    end else begin
      vld_p1 <= 1'b1;
      we_p1  <= bus.id_we;
      ld_p1  <= bus.id_ld;
      dst_p1 <= bus.id_dst_addr;
      op0_p1 <= fwd0_p0;
      op1_p1 <= fwd1_p0;
    end
  end

  assign bus.ex_valid    = vld_p1;
  assign bus.ex_we       = we_p1;
  assign bus.ex_ld       = ld_p1;
  assign bus.ex_dst_addr = dst_p1;
  assign bus.ex_op0      = op0_p1;
  assign bus.ex_op1      = op1_p1;

endmodule
